// File: rtl/pico_ahb_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the PicoRV32-to-AHB bridge.
package pico_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/pico_ahb_master_if.sv
// CPU native memory port plus AHB-Lite master signals, bundled for the bridge.
interface pico_ahb_master_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, bus_err,
        output htrans, hwrite, hsize, haddr, hburst, hprot, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, bus_err,
        input  htrans, hwrite, hsize, haddr, hburst, hprot, hwdata,
        output hready, hresp, hrdata
    );

endinterface

// File: rtl/pico_ahb_master_wstrb_dec.sv
// Maps PicoRV32 byte strobes onto AHB size, low address bits and direction.
module pico_wstrb_dec
    import pico_ahb_pkg::*;
(
    input  logic [3:0] wstrb,
    output logic [2:0] hsize,
    output logic [1:0] addr_lo,
    output logic       hwrite,
    output logic       illegal
);

    always_comb begin
        hsize   = HSIZE_WORD;
        addr_lo = 2'b00;
        hwrite  = 1'b1;
        illegal = 1'b0;
        case (wstrb)
            4'b0000: hwrite = 1'b0;
            4'b0001: begin hsize = HSIZE_BYTE; addr_lo = 2'b00; end
            4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
            4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
            4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
            4'b0011: begin hsize = HSIZE_HALF; addr_lo = 2'b00; end
            4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
            4'b1111: hsize = HSIZE_WORD;
            default: begin
                hwrite  = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pico_ahb_master.sv
// PicoRV32 native memory port to single-master AHB-Lite bridge.
// One SINGLE transfer per CPU request; every output comes straight from a flop.
module pico_ahb_master
    import pico_ahb_pkg::*;
#(
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000,
    parameter logic        PRIV      = 1'b1
) (
    input  logic             hclk,
    input  logic             hreset_n,
    pico_ahb_master_if.master bus
);

    state_e      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] haddr_q, haddr_d;
    logic [3:0]  hprot_q, hprot_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_err_q, bus_err_d;

    logic [2:0]  dec_hsize;
    logic [1:0]  dec_addr_lo;
    logic        dec_hwrite;
    logic        dec_illegal;
    logic [1:0]  unused_addr_lo;

    assign unused_addr_lo = bus.mem_addr[1:0];

    pico_wstrb_dec u_wstrb_dec (
        .wstrb   (bus.mem_wstrb),
        .hsize   (dec_hsize),
        .addr_lo (dec_addr_lo),
        .hwrite  (dec_hwrite),
        .illegal (dec_illegal)
    );

    // In DONE, mem_ready_q still low means we arrived straight from IDLE on an
    // illegal strobe: spend one extra cycle so the pulse lands two cycles after acceptance.
    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        haddr_d     = haddr_q;
        hprot_d     = hprot_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = 32'h0000_0000;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_valid && !mem_ready_q) begin
                    hwrite_d = dec_hwrite;
                    hsize_d  = dec_hsize;
                    haddr_d  = {bus.mem_addr[31:2], dec_addr_lo};
                    hprot_d  = {2'b00, PRIV, ~bus.mem_instr};
                    wdata_d  = bus.mem_wdata;
                    if (dec_illegal) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.hready) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                end
            end
            ST_DATA: begin
                if (bus.hready) begin
                    state_d     = ST_DONE;
                    mem_ready_d = 1'b1;
                    if (bus.hresp == HRESP_ERROR) begin
                        mem_rdata_d = ERR_RDATA;
                        bus_err_d   = 1'b1;
                    end else begin
                        mem_rdata_d = hwrite_q ? 32'h0000_0000 : bus.hrdata;
                    end
                end
            end
            ST_DONE: begin
                if (!mem_ready_q) begin
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ERR_RDATA;
                    bus_err_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_WORD;
            haddr_q     <= 32'h0000_0000;
            hprot_q     <= {2'b00, PRIV, 1'b1};
            hwdata_q    <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0000_0000;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            haddr_q     <= haddr_d;
            hprot_q     <= hprot_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.htrans    = htrans_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = hsize_q;
    assign bus.haddr     = haddr_q;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hprot     = hprot_q;
    assign bus.hwdata    = hwdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.bus_err   = bus_err_q;

endmodule
